// File: rtl/div_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_ctrl
// Purpose  : Sequencer for an iterative 32-bit divider: latches operands,
//            clears the datapath, counts ITER iterations and captures HI/LO.
// Options  : DIV_ZERO_FASTPATH_EN - a zero divisor completes immediately.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module div_ctrl #(
  parameter int ITER  = 33,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend_in,
  input  logic [31:0] divisor_in,
  input  logic [31:0] dp_hi,
  input  logic [31:0] dp_lo,
  input  logic        dp_exc,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        dp_reset,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_div0_pend;
  logic             w_accept;
  logic             w_last;
  logic             w_zero_fast;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_zero_fast = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    div0        = 1'b0;
    // Datapath is held cleared for the whole time reset is asserted.
    dp_reset    = !reset;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
          w_zero_fast = (divisor_in == 32'd0);
`else
          w_zero_fast = 1'b0;
`endif
          w_next = w_zero_fast ? S_DONE : S_CLR;
        end
      end
      S_CLR: begin
        busy     = 1'b1;
        dp_reset = 1'b1;
        w_next   = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        // abort wins over the final iteration, so no capture happens.
        if (abort) begin
          w_next = S_IDLE;
        end else if (r_cnt == C_LAST) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        div0   = r_div0_pend;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_div0_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a      <= dividend_in;
        r_op_b      <= divisor_in;
        r_div0_pend <= w_zero_fast;
      end
      if (r_state == S_CLR)      r_cnt <= '0;
      else if (r_state == S_RUN) r_cnt <= r_cnt + C_ONE;
      // A divide-by-zero leaves the architectural HI/LO untouched.
      if (w_last) begin
        r_div0_pend <= dp_exc;
        if (!dp_exc) begin
          r_hi <= dp_hi;
          r_lo <= dp_lo;
        end
      end
    end
  end

  assign op_a   = r_op_a;
  assign op_b   = r_op_b;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter ITER, default 33, meaning the number of datapath iteration cycles per division.
REQ-002 Parameter CNT_W, default 6, meaning the iteration counter width; it SHALL satisfy 2^CNT_W > ITER.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  in  1  division request from the control unit, sampled in IDLE only.
REQ-006 abort  in  1  synchronous cancel of an in-flight division.
REQ-007 dividend_in  in  32  dividend operand, sampled with start.
REQ-008 divisor_in  in  32  divisor operand, sampled with start.
REQ-009 dp_hi, dp_lo  in  32 each  remainder and quotient from the iterative divider datapath.
REQ-010 dp_exc  in  1  divide-by-zero flag from the datapath.
REQ-011 op_a, op_b  out  32 each  latched dividend and divisor driven to the datapath.
REQ-012 dp_reset  out  1  active-high, one-cycle clear to the datapath.
REQ-013 busy  out  1  high while a division is in flight; used as the CPU stall.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 div0  out  1  one-cycle divide-by-zero exception, coincident with done.
REQ-016 hi_out, lo_out  out  32 each  registered remainder and quotient for the HI/LO registers.

Function
REQ-017 The FSM SHALL have four states: IDLE, CLR, RUN and DONE, with a registered state encoding.
REQ-018 In IDLE with start=1, the block SHALL latch op_a<=dividend_in, op_b<=divisor_in and go to CLR.
REQ-019 In CLR, the block SHALL assert dp_reset=1 for exactly that cycle, clear the counter to 0 and go to RUN.
REQ-020 In RUN, the counter SHALL increment by 1 each cycle.
REQ-021 In RUN at counter==ITER-1, the block SHALL capture hi_out<=dp_hi and lo_out<=dp_lo, set a pending div0 flag to dp_exc, and go to DONE.
REQ-022 On a divide-by-zero completion, hi_out and lo_out SHALL keep their previous values instead of being captured.
REQ-023 In DONE, done=1 and div0=pending flag for exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-024 busy SHALL be 1 in CLR and RUN, and 0 in IDLE and DONE.
REQ-025 Latency from the start-sampling edge to done high SHALL be ITER+2 cycles: one CLR cycle, ITER RUN cycles, then DONE.
REQ-026 start SHALL be ignored in CLR, RUN and DONE; a start held through DONE SHALL be accepted on the first IDLE cycle.
REQ-027 abort=1 in CLR or RUN SHALL return the FSM to IDLE next cycle with no done, no div0 and hi_out/lo_out unchanged.
REQ-028 abort SHALL take priority over the ITER-1 completion in the same cycle.
REQ-029 abort SHALL have no effect in IDLE or DONE.
REQ-030 op_a and op_b SHALL hold their values from acceptance until the next accepted start.

Reset
REQ-031 While reset=0, the block SHALL asynchronously force state=IDLE, counter=0, op_a=op_b=0, hi_out=lo_out=0, and busy=done=div0=0.
REQ-032 While reset=0, the block SHALL force dp_reset=1, so the datapath is held cleared during reset.
REQ-033 Reset asserted mid-RUN SHALL discard the operation; after release the block SHALL be in IDLE with no done pulse.

Configuration
REQ-034 The feature SHALL be controlled by the macro DIV_ZERO_FASTPATH_EN.
REQ-035 With DIV_ZERO_FASTPATH_EN defined, start with divisor_in==0 in IDLE SHALL go directly to DONE, skipping CLR and RUN, with div0=1.
REQ-036 In the fast path, done SHALL rise 1 cycle after the start-sampling edge and the datapath SHALL never be cleared.
REQ-037 Without DIV_ZERO_FASTPATH_EN, a zero divisor SHALL follow the full ITER+2 sequence and div0 SHALL come solely from dp_exc.

Verification
REQ-038 Normal divide: dividend_in=100, divisor_in=7, start pulse -> busy for 34 cycles, done at cycle 35, lo_out=14, hi_out=2, div0=0.
REQ-039 Zero divisor: dividend_in=5, divisor_in=0.
  - With the macro: done=div0=1 at cycle 1, busy never high.
  - Without the macro: done=div0=1 at cycle 35.
  - In both cases hi_out/lo_out keep their previous values.
REQ-040 start held high while busy, with operands changed to 9/3 mid-run -> operands not re-latched; the first result is 100/7.
  - The new request is accepted only after DONE.
REQ-041 abort=1 at RUN counter==32 (the completion cycle) -> IDLE next cycle, no done, hi_out/lo_out unchanged.
REQ-042 reset=0 at RUN counter==10 -> all outputs 0 immediately and dp_reset=1.
  - After release with start=0: stays in IDLE, no done.
